// File: rtl/gh_pkg.sv
// gh_pkg: shared constants, state encoding and padding helper
// for the Streebog message-level controller.
package gh_pkg;

  localparam logic [511:0] IV_512 = '0;
  localparam logic [511:0] IV_256 = {64{8'h01}};
  localparam int ROUND_LAT_DEF = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FIN_N,
    S_FIN_S,
    S_DONE
  } gh_state_e;

  function automatic logic [511:0] gh_pad(
    input logic [511:0] data,
    input logic [8:0]   nbits
  );
    logic [511:0] mark;
    mark = 512'd1 << nbits;
    return (data & (mark - 512'd1)) | mark;
  endfunction

endpackage

// File: rtl/gh_wait_cnt.sv
// gh_wait_cnt: loadable clken-qualified down-counter
// with a zero flag, used to time the round latency.
module gh_wait_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clken,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clken) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gh_hash_ctrl.sv
// gh_hash_ctrl: Streebog message controller; feeds the
// external round, tracks h/N/Sigma and runs finalisation.
module gh_hash_ctrl
  import gh_pkg::*;
#(
  parameter int ROUND_LAT = ROUND_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clken,
  input  logic         cfg_256,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_last,
  input  logic [8:0]   in_nbits,
  output logic [511:0] rnd_hash,
  output logic [511:0] rnd_numbits,
  output logic [511:0] rnd_data,
  input  logic [511:0] rnd_hash_out,
  output logic         out_valid,
  output logic [511:0] out_hash,
  input  logic         out_ready
);

  gh_state_e state_q, state_d;
  gh_state_e ret_q, ret_d;

  logic [511:0] h_q, h_d;
  logic [511:0] n_q, n_d;
  logic [511:0] sig_q, sig_d;
  logic         act_q, act_d;
  logic         m256_q, m256_d;
  logic [511:0] rh_q, rh_d;
  logic [511:0] rn_q, rn_d;
  logic [511:0] rd_q, rd_d;
  logic         ov_q, ov_d;
  logic [511:0] oh_q, oh_d;

  logic         load;
  logic         cnt_zero;
  logic [511:0] h_base;
  logic [511:0] pad;

  gh_wait_cnt #(.W(6)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .load     (load),
    .load_val (6'(ROUND_LAT)),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    h_d     = h_q;
    n_d     = n_q;
    sig_d   = sig_q;
    act_d   = act_q;
    m256_d  = m256_q;
    rh_d    = rh_q;
    rn_d    = rn_q;
    rd_d    = rd_q;
    ov_d    = ov_q;
    oh_d    = oh_q;
    load    = 1'b0;
    h_base  = h_q;
    pad     = gh_pad(in_data, in_nbits);

    unique case (state_q)
      S_IDLE: begin
        if (clken && in_valid) begin
          // first beat of a message seeds h and latches the mode
          if (!act_q) begin
            h_base = cfg_256 ? IV_256 : IV_512;
            m256_d = cfg_256;
          end
          act_d   = 1'b1;
          h_d     = h_base;
          rh_d    = h_base;
          rn_d    = n_q;
          load    = 1'b1;
          state_d = S_WAIT;
          if (in_last) begin
            rd_d  = pad;
            n_d   = n_q + {503'b0, in_nbits};
            sig_d = sig_q + pad;
            ret_d = S_FIN_N;
          end else begin
            rd_d  = in_data;
            n_d   = n_q + 512'd512;
            sig_d = sig_q + in_data;
            ret_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (clken && cnt_zero) begin
          h_d     = rnd_hash_out;
          state_d = ret_q;
        end
      end
      S_FIN_N: begin
        if (clken) begin
          rh_d    = h_q;
          rn_d    = '0;
          rd_d    = n_q;
          ret_d   = S_FIN_S;
          load    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_FIN_S: begin
        if (clken) begin
          rh_d    = h_q;
          rn_d    = '0;
          rd_d    = sig_q;
          ret_d   = S_DONE;
          load    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (clken) begin
          if (!ov_q) begin
            ov_d = 1'b1;
            oh_d = m256_q ? {256'b0, h_q[511:256]} : h_q;
          end else if (out_ready) begin
            ov_d    = 1'b0;
            h_d     = '0;
            n_d     = '0;
            sig_d   = '0;
            act_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      h_q     <= '0;
      n_q     <= '0;
      sig_q   <= '0;
      act_q   <= 1'b0;
      m256_q  <= 1'b0;
      rh_q    <= '0;
      rn_q    <= '0;
      rd_q    <= '0;
      ov_q    <= 1'b0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      h_q     <= h_d;
      n_q     <= n_d;
      sig_q   <= sig_d;
      act_q   <= act_d;
      m256_q  <= m256_d;
      rh_q    <= rh_d;
      rn_q    <= rn_d;
      rd_q    <= rd_d;
      ov_q    <= ov_d;
      oh_q    <= oh_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign rnd_hash    = rh_q;
  assign rnd_numbits = rn_q;
  assign rnd_data    = rd_q;
  assign out_valid   = ov_q;
  assign out_hash    = oh_q;

endmodule

// File: tb/tb_gh_hash_ctrl.sv
// tb_gh_hash_ctrl: drives gh_hash_ctrl with a 40-deep stand-in
// round and checks digests against a message-level reference.
module tb_gh_hash_ctrl;

  localparam int LAT = 40;

  logic         clk;
  logic         rst_n;
  logic         clken;
  logic         cfg_256;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         in_last;
  logic [8:0]   in_nbits;
  logic [511:0] rnd_hash;
  logic [511:0] rnd_numbits;
  logic [511:0] rnd_data;
  logic [511:0] rnd_hash_out;
  logic         out_valid;
  logic [511:0] out_hash;
  logic         out_ready;

  int errors = 0;
  int checks = 0;
  bit ce_rand = 0;

  logic [511:0] blks [$];
  logic [511:0] lastd;
  int           lastnb;
  bit           m256;
  logic [511:0] dig_1024;

  gh_hash_ctrl #(.ROUND_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clken        (clken),
    .cfg_256      (cfg_256),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_nbits     (in_nbits),
    .rnd_hash     (rnd_hash),
    .rnd_numbits  (rnd_numbits),
    .rnd_data     (rnd_data),
    .rnd_hash_out (rnd_hash_out),
    .out_valid    (out_valid),
    .out_hash     (out_hash),
    .out_ready    (out_ready)
  );

  // stand-in compression: any mixing of (h, N, m) works here
  function automatic logic [511:0] f_round(
    input logic [511:0] h,
    input logic [511:0] n,
    input logic [511:0] m
  );
    logic [511:0] x;
    x = (h ^ m) + n * 512'h9E3779B97F4A7C15;
    x = x ^ {x[476:0], x[511:477]};
    x = x + {x[255:0], x[511:256]} * 512'd5;
    return x ^ h;
  endfunction

  logic [511:0] pipe [LAT];

  always @(posedge clk) begin
    if (clken) begin
      pipe[0] <= f_round(rnd_hash, rnd_numbits, rnd_data);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rnd_hash_out = pipe[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] rnd512();
    logic [511:0] x;
    for (int j = 0; j < 16; j++) x[j*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic logic [511:0] ref_digest();
    logic [511:0] h, n, s, p;
    h = m256 ? {64{8'h01}} : 512'd0;
    n = 0;
    s = 0;
    foreach (blks[i]) begin
      h = f_round(h, n, blks[i]);
      n = n + 512;
      s = s + blks[i];
    end
    p = 0;
    for (int i = 0; i < lastnb; i++) p[i] = lastd[i];
    p[lastnb] = 1'b1;
    h = f_round(h, n, p);
    n = n + 512'(lastnb);
    s = s + p;
    h = f_round(h, 512'd0, n);
    h = f_round(h, 512'd0, s);
    return m256 ? {256'b0, h[511:256]} : h;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clken = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_beat(input string tag, input logic [511:0] d,
                           input bit last, input int nb);
    bit done;
    int g;
    done = 0;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_nbits = 9'(nb);
    while (!done && g < 2000) begin
      if (in_ready && clken) done = 1;
      tick();
      g++;
    end
    in_valid = 1'b0;
    in_data  = rnd512();
    chk({tag, "_acc_to"}, 512'(g >= 2000), 512'd0);
  endtask

  task automatic wait_ready(input string tag);
    int low, g;
    low = 0;
    g = 0;
    while (!in_ready && g < 2000) begin
      if (clken) low++;
      tick();
      g++;
    end
    chk({tag, "_rdy_low"}, 512'(low), 512'd41);
  endtask

  task automatic run_msg(input string tag, input int stall);
    logic [511:0] exp;
    bit held;
    bit done;
    int g;
    exp = ref_digest();
    cfg_256 = m256;
    foreach (blks[i]) begin
      send_beat(tag, blks[i], 1'b0, 0);
      cfg_256 = ~m256;
      wait_ready(tag);
    end
    send_beat(tag, lastd, 1'b1, lastnb);
    cfg_256 = ~m256;
    if (blks.size() > 0) begin
      g = 0;
      while (rnd_numbits !== 512'd0 && g < 300) begin
        tick();
        g++;
      end
      chk({tag, "_fin_n"}, rnd_data, 512'(512 * blks.size() + lastnb));
    end
    g = 0;
    while (!out_valid && g < 3000) begin
      tick();
      g++;
    end
    chk({tag, "_ov_to"}, 512'(g >= 3000), 512'd0);
    chk({tag, "_digest"}, out_hash, exp);
    held = 1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!(out_valid === 1'b1 && out_hash === exp)) held = 0;
    end
    if (stall > 0) chk({tag, "_stall"}, 512'(held), 512'd1);
    out_ready = 1'b1;
    done = 0;
    g = 0;
    while (!done && g < 2000) begin
      if (out_valid && clken) done = 1;
      tick();
      g++;
    end
    out_ready = 1'b0;
    chk({tag, "_post"}, {510'b0, out_valid, in_ready}, 512'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clken     = 1'b1;
    cfg_256   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbits  = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ctl", {509'b0, in_ready, out_valid, 1'b0}, 512'd4);
    chk("rst_oh", out_hash, 512'd0);
    chk("rst_rnd", rnd_hash | rnd_numbits | rnd_data, 512'd0);
    rst_n = 1'b1;
    tick();

    blks = {};
    lastd = {8'h00,
      "012345678901234567890123456789012345678901234567890123456789012"};
    lastnb = 504;
    m256 = 0;
    run_msg("m1_512", 0);
    m256 = 1;
    run_msg("m1_256", 0);

    lastd = rnd512();
    lastnb = 0;
    m256 = 0;
    run_msg("empty", 0);

    blks = {rnd512(), rnd512()};
    lastd = rnd512();
    lastnb = 0;
    m256 = 0;
    dig_1024 = ref_digest();
    run_msg("m1024", 0);
    ce_rand = 1;
    run_msg("m1024_ce", 100);
    ce_rand = 0;
    clken = 1'b1;

    for (int r = 0; r < 4; r++) begin
      blks = {};
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        blks.push_back(rnd512());
      lastd = rnd512();
      lastnb = (r == 0) ? 511 : int'($urandom_range(0, 511));
      m256 = 1'($urandom_range(0, 1));
      ce_rand = 1'(r % 2);
      run_msg($sformatf("rnd%0d", r), 5);
    end
    ce_rand = 0;
    clken = 1'b1;

    blks = {rnd512(), rnd512()};
    cfg_256 = 1'b0;
    send_beat("rstw", blks[0], 1'b0, 0);
    wait_ready("rstw");
    send_beat("rstw", blks[1], 1'b0, 0);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rstw_ctl", {510'b0, in_ready, out_valid}, 512'd2);
    chk("rstw_rnd", rnd_hash | rnd_numbits | rnd_data, 512'd0);
    chk("rstw_oh", out_hash, 512'd0);
    #2;
    rst_n = 1'b1;
    tick();
    blks = {};
    lastd = {8'h00,
      "012345678901234567890123456789012345678901234567890123456789012"};
    lastnb = 504;
    m256 = 0;
    run_msg("m1_again", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
